// File: rtl/echo_pkg.sv
// Shared types and defaults for the echo capture receive path.
// State encoding plus the ADC mid-scale code used for rectification.
package echo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 10;
  localparam int DLYW_DEF = 16;
  localparam int MID_DEF  = 128;

endpackage

// File: rtl/echo_buf.sv
// Echo sample buffer: one write port, one registered read port.
// A read of the address being written returns the old word.
module echo_buf
  import echo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd <= '0;
    else        rd <= mem[ra];
  end

endmodule

// File: rtl/echo_capture.sv
// Trigger-synchronous echo acquisition: blanking delay, sample window,
// time-of-flight to first threshold crossing and peak amplitude.
module echo_capture
  import echo_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int DLYW = DLYW_DEF,
  parameter int MID  = MID_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trig,
  input  logic            arm,
  input  logic [DLYW-1:0] cfg_delay,
  input  logic [AW:0]     cfg_len,
  input  logic [DW-1:0]   cfg_thresh,
  input  logic [DW-1:0]   adc_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            armed,
  output logic            busy,
  output logic            done,
  output logic            echo_found,
  output logic [DLYW-1:0] echo_tof,
  output logic [DW-1:0]   peak_amp,
  output logic [AW-1:0]   peak_idx,
  output logic            overrun
);

  localparam logic [DW-1:0] MIDV = DW'(MID);
  localparam logic [AW:0]   LMAX = (AW+1)'(2**AW);

  state_t state, state_nx;

  logic            trig_d;
  logic            rise;
  logic            start;
  logic            we;
  logic [DLYW-1:0] dly_q;
  logic [DLYW-1:0] dcnt;
  logic [AW-1:0]   last_q;
  logic [AW-1:0]   last_nx;
  logic [AW-1:0]   idx;
  logic [DW-1:0]   thr_q;
  logic [DW-1:0]   amp;
  logic [DLYW:0]   tof_sum;
  logic [DLYW-1:0] tof_sat;

  assign rise  = trig & ~trig_d;
  assign start = (state == S_ARMED) && rise;

  assign amp = (adc_data >= MIDV) ? adc_data - MIDV
                                  : MIDV - adc_data;

  assign tof_sum = {1'b0, dly_q} + (DLYW+1)'(idx);
  assign tof_sat = tof_sum[DLYW] ? '1 : tof_sum[DLYW-1:0];

  // Window holds index of the last sample; oversize lengths clamp to the buffer.
  always_comb begin
    last_nx = '0;
    if (cfg_len == '0)       last_nx = '0;
    else if (cfg_len > LMAX) last_nx = '1;
    else                     last_nx = AW'(cfg_len - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (arm) state_nx = S_ARMED;
      S_ARMED:   if (rise)
                   state_nx = (cfg_delay == '0) ? S_CAPTURE
                                                : S_DELAY;
      S_DELAY:   if (dcnt == dly_q - 1'b1) state_nx = S_CAPTURE;
      S_CAPTURE: if (idx == last_q) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    armed = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    we    = 1'b0;
    unique case (state)
      S_ARMED:   armed = 1'b1;
      S_DELAY:   busy  = 1'b1;
      S_CAPTURE: begin
        busy = 1'b1;
        we   = 1'b1;
      end
      S_DONE:    done  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_d     <= 1'b1;
      dly_q      <= '0;
      dcnt       <= '0;
      last_q     <= '0;
      idx        <= '0;
      thr_q      <= '0;
      echo_found <= 1'b0;
      echo_tof   <= '0;
      peak_amp   <= '0;
      peak_idx   <= '0;
      overrun    <= 1'b0;
    end else begin
      trig_d <= trig;
      if (state == S_IDLE && arm) overrun <= 1'b0;
      else if (rise && busy)      overrun <= 1'b1;
      if (start) begin
        dly_q      <= cfg_delay;
        last_q     <= last_nx;
        thr_q      <= cfg_thresh;
        dcnt       <= '0;
        idx        <= '0;
        echo_found <= 1'b0;
        echo_tof   <= '0;
        peak_amp   <= '0;
        peak_idx   <= '0;
      end
      if (state == S_DELAY) dcnt <= dcnt + 1'b1;
      if (state == S_CAPTURE) begin
        idx <= idx + 1'b1;
        if (!echo_found && amp >= thr_q) begin
          echo_found <= 1'b1;
          echo_tof   <= tof_sat;
        end
        if (amp > peak_amp) begin
          peak_amp <= amp;
          peak_idx <= idx;
        end
      end
    end
  end

  echo_buf #(
    .DW(DW),
    .AW(AW)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .wa   (idx),
    .wd   (adc_data),
    .ra   (rd_addr),
    .rd   (rd_data)
  );

endmodule

// File: tb/tb_echo_capture.sv
// Bench for echo_capture: fixed vectors, random windows against a
// sample-list reference, and reset / overrun sequences.
module tb_echo_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic        arm;
  logic [15:0] cfg_delay;
  logic [10:0] cfg_len;
  logic [7:0]  cfg_thresh;
  logic [7:0]  adc_data;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        armed;
  logic        busy;
  logic        done;
  logic        echo_found;
  logic [15:0] echo_tof;
  logic [7:0]  peak_amp;
  logic [9:0]  peak_idx;
  logic        overrun;

  echo_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .arm       (arm),
    .cfg_delay (cfg_delay),
    .cfg_len   (cfg_len),
    .cfg_thresh(cfg_thresh),
    .adc_data  (adc_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .armed     (armed),
    .busy      (busy),
    .done      (done),
    .echo_found(echo_found),
    .echo_tof  (echo_tof),
    .peak_amp  (peak_amp),
    .peak_idx  (peak_idx),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  typedef struct {
    int d;
    int l;
    int thr;
    int base;
    int ramp;
    int s1;
    int s2;
    int sv;
    int retrig;
    int e_found;
    int e_tof;
    int e_pamp;
    int e_pidx;
  } vec_t;

  vec_t       tv[7];
  logic [7:0] smp[1024];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int rect(input logic [7:0] s);
    int v;
    v = int'(s);
    return (v >= 128) ? v - 128 : 128 - v;
  endfunction

  // Reference: scan the sample list for first crossing and first maximum.
  task automatic model(input int d, input int leff, input int thr,
                       output int f, output int t,
                       output int pa, output int pi);
    f = 0; t = 0; pa = 0; pi = 0;
    for (int i = 0; i < leff; i++) begin
      if (f == 0 && rect(smp[i]) >= thr) begin
        f = 1;
        t = (d + i > 65535) ? 65535 : d + i;
      end
      if (rect(smp[i]) > pa) pa = rect(smp[i]);
    end
    for (int i = leff - 1; i >= 0; i--)
      if (rect(smp[i]) == pa) pi = i;
  endtask

  task automatic acquire(input string nm, input int d, input int lc,
                         input int thr, input int rt);
    int leff, dk, nd, berr, n;
    leff = (lc == 0) ? 1 : lc;
    dk = -1; nd = 0; berr = 0;
    trig = 1'b0;
    cfg_delay  = 16'(d);
    cfg_len    = 11'(lc);
    cfg_thresh = 8'(thr);
    @(posedge clk); #1;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    chk({nm, "_armed"}, armed, 1);
    chk({nm, "_ovr_clr"}, overrun, 0);
    trig = 1'b1;
    n = d + leff + 8;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        cfg_delay  = 16'($urandom);
        cfg_len    = 11'($urandom);
        cfg_thresh = 8'($urandom);
      end
      if (k - 1 - d >= 0 && k - 1 - d < leff) adc_data = smp[k-1-d];
      else adc_data = 8'($urandom);
      if (rt > 0) begin
        if (k == rt)     trig = 1'b0;
        if (k == rt + 2) trig = 1'b1;
        if (k == rt + 4) arm  = 1'b1;
        if (k == rt + 5) arm  = 1'b0;
      end
      if (busy !== (k <= d + leff)) berr++;
      if (done === 1'b1) begin
        nd++;
        dk = k;
      end
    end
    trig = 1'b0;
    chk({nm, "_done_cnt"}, nd, 1);
    chk({nm, "_done_cyc"}, dk, d + leff + 1);
    chk({nm, "_busy_win"}, berr, 0);
    chk({nm, "_overrun"}, overrun, (rt > 0) ? 1 : 0);
  endtask

  task automatic check_buf(input string nm, input int leff);
    int errs;
    errs = 0;
    for (int a = 0; a < leff; a++) begin
      rd_addr = 10'(a);
      @(posedge clk); #1;
      if (rd_data !== smp[a]) begin
        if (errs == 0)
          $display("FAIL %s_buf[%0d]: got %0d want %0d",
                   nm, a, rd_data, smp[a]);
        errs++;
      end
    end
    chk({nm, "_buf_errs"}, errs, 0);
  endtask

  task automatic check_res(input string nm, input int f, input int t,
                           input int pa, input int pi);
    chk({nm, "_found"}, echo_found, f);
    chk({nm, "_tof"}, echo_tof, t);
    chk({nm, "_pamp"}, peak_amp, pa);
    chk({nm, "_pidx"}, peak_idx, pi);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int errs, leff, d, lc, thr, f, t, pa, pi;
    string nm;

    tv[0] = '{10, 16,   40, 128, 0,  5, -1, 200,  0, 1, 15, 72, 5};
    tv[1] = '{10, 16,   40, 128, 0,  5, -1, 200, 15, 1, 15, 72, 5};
    tv[2] = '{ 3,  8,   40, 130, 0, -1, -1,   0,  0, 0,  0,  2, 0};
    tv[3] = '{ 0, 1024,  0,   0, 1, -1, -1,   0,  0, 1,  0, 128, 0};
    tv[4] = '{ 2,  0,   28, 100, 0, -1, -1,   0,  0, 1,  2, 28, 0};
    tv[5] = '{ 1,  8,  100, 128, 0,  2,  6, 150,  0, 0,  0, 22, 2};
    tv[6] = '{ 5,  4,    0, 128, 0, -1, -1,   0,  0, 1,  5,  0, 0};

    rst_n = 1'b0; trig = 1'b1; arm = 1'b0;
    cfg_delay = '0; cfg_len = '0; cfg_thresh = '0;
    adc_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        {armed, busy, done, echo_found, echo_tof,
         peak_amp, peak_idx, overrun, rd_data}, 0);
    rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      trig = ~trig;
      if ({armed, busy, done} !== 3'b000) errs++;
    end
    chk("no_arm_idle", errs, 0);

    for (int v = 0; v < 7; v++) begin
      nm = $sformatf("v%0d", v);
      for (int i = 0; i < 1024; i++)
        smp[i] = (tv[v].ramp != 0) ? 8'(i) : 8'(tv[v].base);
      if (tv[v].s1 >= 0) smp[tv[v].s1] = 8'(tv[v].sv);
      if (tv[v].s2 >= 0) smp[tv[v].s2] = 8'(tv[v].sv);
      leff = (tv[v].l == 0) ? 1 : tv[v].l;
      acquire(nm, tv[v].d, tv[v].l, tv[v].thr, tv[v].retrig);
      check_res(nm, tv[v].e_found, tv[v].e_tof,
                tv[v].e_pamp, tv[v].e_pidx);
      check_buf(nm, leff);
    end

    for (int r = 0; r < 8; r++) begin
      nm  = $sformatf("r%0d", r);
      d   = $urandom_range(0, 20);
      lc  = $urandom_range(0, 80);
      thr = $urandom_range(0, 130);
      for (int i = 0; i < 1024; i++) smp[i] = 8'($urandom);
      leff = (lc == 0) ? 1 : lc;
      model(d, leff, thr, f, t, pa, pi);
      acquire(nm, d, lc, thr, 0);
      check_res(nm, f, t, pa, pi);
      check_buf(nm, leff);
    end

    // Reset in the middle of a capture window.
    for (int i = 0; i < 1024; i++) smp[i] = 8'd255;
    trig = 1'b0;
    cfg_delay = 16'd2; cfg_len = 11'd100; cfg_thresh = 8'd10;
    @(posedge clk); #1;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    trig = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      adc_data = smp[0];
    end
    chk("rst6_busy_before", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst6_busy", busy, 0);
    chk("rst6_res", {echo_found, echo_tof, peak_amp, peak_idx}, 0);
    errs = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (k == 3) rst_n = 1'b1;
      trig = (k % 4) < 2;
      if ({armed, busy, done} !== 3'b000) errs++;
    end
    chk("rst6_idle", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
